// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side VGA timing checker.
// Recovers pixel coordinates from hsync/vsync, tracks timing lock and
// reports per-frame lit-pixel counts and a saturating timing-error count.
`timescale 1ns / 1ps

module vga_frame_monitor #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic        i_clk_25MHz,
   input  logic        i_reset,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_red,
   input  logic        i_green,
   input  logic        i_blue,
   output logic [9:0]  o_x,
   output logic [9:0]  o_y,
   output logic [2:0]  o_rgb,
   output logic        o_pixel_valid,
   output logic        o_locked,
   output logic        o_frame_done,
   output logic [18:0] o_lit_count,
   output logic [7:0]  o_error_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] POS_MAX   = 10'd1023;
   localparam logic [9:0] H_LAST_P  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST_P  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_P  = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_P  = 10'(V_SYNC);
   localparam logic [9:0] H_START_P = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_END_P   = 10'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [9:0] V_START_P = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_END_P   = 10'(V_SYNC + V_BACK + V_VISIBLE);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // sample stage (syncs already normalised to active-high)
   logic        hs_r, hs_d_r, vs_r, vs_d_r;
   logic [2:0]  rgb_r;

   // position tracking
   logic [9:0]  hpos_r, vpos_r;
   logic [9:0]  hpos_s, vpos_s;
   logic        hs_edge_s, hs_fall_s, vs_edge_s, vs_fall_s;
   logic        visible_s;

   // error detection
   logic        h_en_r, v_en_r;
   logic        h_len_err_s, h_width_err_s, v_len_err_s, v_width_err_s;
   logic        err_s;

   // lock FSM and statistics
   state_t      state_r, next_state_s;
   logic        chk_err_r;
   logic        lock_next_s, pix_valid_s, frame_ok_s, lit_s;
   logic [18:0] acc_r;

   // Register the pins once and normalise sync polarity to active-high.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         hs_r   <= 1'b0;
         hs_d_r <= 1'b0;
         vs_r   <= 1'b0;
         vs_d_r <= 1'b0;
         rgb_r  <= 3'b000;
      end else begin
         hs_r   <= (SYNC_ACTIVE_LOW != 0) ? ~i_hsync : i_hsync;
         vs_r   <= (SYNC_ACTIVE_LOW != 0) ? ~i_vsync : i_vsync;
         hs_d_r <= hs_r;
         vs_d_r <= vs_r;
         rgb_r  <= {i_red, i_green, i_blue};
      end
   end

   // Edge detection and recovered position of the sample now in the stage.
   always_comb begin
      hs_edge_s = hs_r & ~hs_d_r;
      hs_fall_s = ~hs_r & hs_d_r;
      vs_edge_s = vs_r & ~vs_d_r;
      vs_fall_s = ~vs_r & vs_d_r;

      if (hs_edge_s) begin
         hpos_s = 10'd0;
      end else if (hpos_r == POS_MAX) begin
         hpos_s = POS_MAX;
      end else begin
         hpos_s = hpos_r + 10'd1;
      end

      // vsync edge wins over a coincident hsync edge
      if (vs_edge_s) begin
         vpos_s = 10'd0;
      end else if (hs_edge_s) begin
         if (vpos_r == POS_MAX) begin
            vpos_s = POS_MAX;
         end else begin
            vpos_s = vpos_r + 10'd1;
         end
      end else begin
         vpos_s = vpos_r;
      end

      visible_s = (hpos_s >= H_START_P) && (hpos_s < H_END_P) &&
                  (vpos_s >= V_START_P) && (vpos_s < V_END_P);
   end

   // Hold the position of the previous sample for length checks.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         hpos_r <= 10'd0;
         vpos_r <= 10'd0;
      end else begin
         hpos_r <= hpos_s;
         vpos_r <= vpos_s;
      end
   end

   // Checks stay disabled until each sync has produced its first edge.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         h_en_r <= 1'b0;
         v_en_r <= 1'b0;
      end else begin
         h_en_r <= h_en_r | hs_edge_s;
         v_en_r <= v_en_r | vs_edge_s;
      end
   end

   // Line/frame length and pulse width checks, merged into one event.
   always_comb begin
      h_len_err_s   = hs_edge_s & h_en_r & (hpos_r != H_LAST_P);
      h_width_err_s = hs_fall_s & h_en_r & (hpos_s != H_SYNC_P);
      v_len_err_s   = vs_edge_s & v_en_r & (vpos_r != V_LAST_P);
      v_width_err_s = vs_fall_s & v_en_r & (vpos_s != V_SYNC_P);
      err_s         = h_len_err_s | h_width_err_s | v_len_err_s | v_width_err_s;
   end

   // Lock FSM state register.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         state_r <= SEARCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Errors since the last vsync edge; a check window opens at each edge.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         chk_err_r <= 1'b0;
      end else if (vs_edge_s) begin
         chk_err_r <= 1'b0;
      end else begin
         chk_err_r <= chk_err_r | err_s;
      end
   end

   // Lock FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         SEARCH: begin
            if (vs_edge_s) begin
               next_state_s = CHECK;
            end else begin
               next_state_s = SEARCH;
            end
         end
         CHECK: begin
            if (vs_edge_s && !(chk_err_r || err_s)) begin
               next_state_s = LOCKED;
            end else begin
               next_state_s = CHECK;
            end
         end
         LOCKED: begin
            if (err_s) begin
               next_state_s = SEARCH;
            end else begin
               next_state_s = LOCKED;
            end
         end
         default: begin
            next_state_s = SEARCH;
         end
      endcase
   end

   // Lock FSM outputs; the state being entered qualifies this sample.
   always_comb begin
      lock_next_s = (next_state_s == LOCKED);
      pix_valid_s = lock_next_s & visible_s;
      frame_ok_s  = (state_r == LOCKED) & vs_edge_s & ~err_s;
      lit_s       = pix_valid_s & (rgb_r != 3'b000);
   end

   // Lit-pixel accumulator for the frame in progress.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         acc_r <= 19'd0;
      end else if (vs_edge_s || err_s) begin
         acc_r <= 19'd0;
      end else if (lit_s) begin
         acc_r <= acc_r + 19'd1;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         o_x           <= 10'd0;
         o_y           <= 10'd0;
         o_rgb         <= 3'b000;
         o_pixel_valid <= 1'b0;
         o_locked      <= 1'b0;
         o_frame_done  <= 1'b0;
         o_lit_count   <= 19'd0;
         o_error_count <= 8'd0;
      end else begin
         o_locked      <= lock_next_s;
         o_pixel_valid <= pix_valid_s;
         o_frame_done  <= frame_ok_s;
         if (pix_valid_s) begin
            o_x   <= hpos_s - H_START_P;
            o_y   <= vpos_s - V_START_P;
            o_rgb <= rgb_r;
         end else begin
            o_x   <= 10'd0;
            o_y   <= 10'd0;
            o_rgb <= 3'b000;
         end
         if (frame_ok_s) begin
            o_lit_count <= acc_r;
         end else begin
            o_lit_count <= o_lit_count;
         end
         if (err_s && (o_error_count != 8'd255)) begin
            o_error_count <= o_error_count + 8'd1;
         end else begin
            o_error_count <= o_error_count;
         end
      end
   end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive end of the VGA link: consumes the hsync/vsync/red/green/blue signals produced by the display controller.
- Recovers pixel coordinates and checks 640x480@60 timing.
- Reports lock status and per-frame lit-pixel statistics.
- Used on the 25MHz clock domain as an on-board self-check of the video output and as the checker in system benches.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, front porch cycles
H_SYNC, 96, hsync pulse cycles
H_BACK, 48, back porch cycles (H_TOTAL = sum = 800)
V_VISIBLE, 480, visible lines
V_FRONT, 10, front porch lines
V_SYNC, 2, vsync pulse lines
V_BACK, 33, back porch lines (V_TOTAL = sum = 525)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low, 0 = high

Ports:
i_clk_25MHz  in  1  pixel clock
i_reset  in  1  synchronous, active-high reset
i_hsync  in  1  horizontal sync from controller
i_vsync  in  1  vertical sync from controller
i_red  in  1  red pixel bit
i_green  in  1  green pixel bit
i_blue  in  1  blue pixel bit
o_x  out  10  recovered column, 0..639
o_y  out  10  recovered row, 0..479
o_rgb  out  3  {red,green,blue} of the current pixel
o_pixel_valid  out  1  o_x/o_y/o_rgb describe a visible pixel while locked
o_locked  out  1  timing lock status
o_frame_done  out  1  one-cycle pulse: a clean frame completed, o_lit_count updated
o_lit_count  out  19  visible pixels with any colour bit set in the last clean frame
o_error_count  out  8  saturating count of timing errors since reset

Behaviour:
- Sampling and polarity
  - All inputs are registered once (sample stage).
  - Syncs are normalised to active-high per SYNC_ACTIVE_LOW.
  - Edges are detected on sampled values: assert edge = active now, inactive in the previous sample.
- Horizontal position (hpos): the sample carrying an hsync assert edge has hpos 0; each later sample is +1, saturating at 1023.
- Vertical position (vpos)
  - The sample carrying a vsync assert edge has vpos 0 and takes priority over a coincident hsync edge.
  - Every other hsync assert edge gives vpos +1, saturating at 1023.
  - A vsync edge in mid-line gives vpos 0 for the rest of that line; the next hsync edge gives vpos 1.
- Visible area
  - hpos in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE) and vpos in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE).
  - x = hpos-144, y = vpos-35 at defaults.
- Errors (each is a one-cycle error event)
  - h_len: at an hsync edge, the previous sample's hpos is not H_TOTAL-1.
  - h_width: at the first inactive hsync sample after an assert, hpos is not H_SYNC.
  - v_len: at a vsync edge, the previous sample's vpos is not V_TOTAL-1.
  - v_width: at the first inactive vsync sample, vpos (including a coincident hsync edge) is not V_SYNC.
  - Errors are evaluated only after the first edge of the respective sync following reset.
  - Multiple errors in one cycle count as one event.
  - o_error_count increments per event and saturates at 255.
- Lock FSM, states SEARCH, CHECK, LOCKED
  - SEARCH: vsync edge -> CHECK.
  - CHECK: vsync edge with no error event since entry -> LOCKED; vsync edge with an error -> stay in CHECK and restart the check.
  - LOCKED: any error event -> SEARCH.
  - o_locked = (state == LOCKED), registered.
- Outputs
  - Registered, so pins to output latency is 2 cycles.
  - o_pixel_valid = LOCKED and visible.
  - When o_pixel_valid is 0, o_x, o_y and o_rgb are 0.
- Lit count
  - The accumulator counts LOCKED visible samples with rgb != 0.
  - At a vsync edge in LOCKED with no error in the frame: o_lit_count is loaded and o_frame_done pulses for 1 cycle.
  - The accumulator clears at every vsync edge and on any error.
- Reset values: every output 0; state SEARCH; hpos/vpos 0; error-evaluation enables cleared.
  - Reset mid-frame discards all partial state.
  - Lock needs one further vsync edge to reach CHECK and then a clean frame to reach LOCKED.

Test Plan:
- Reset, then 3 clean all-black default frames -> o_locked rises 2 cycles after the 2nd vsync edge; o_frame_done at the 3rd edge with o_lit_count = 0; o_error_count = 0.
- Clean frames with a 10x10 white box at (100,50) -> o_pixel_valid with o_x = 100, o_y = 50, o_rgb = 3'b111 at the box corner; o_lit_count = 100; first/last visible pixels map to (0,0) and (639,479).
- One 801-cycle line while LOCKED -> o_locked falls; o_error_count = 1; no o_frame_done for that frame; relock after 2 further clean vsync edges.
- hsync pulse 95 cycles wide -> one h_width error (plus h_len if the line length also changes); o_error_count saturates at 255 under a continuous fault.
- SYNC_ACTIVE_LOW = 0 with inverted syncs -> identical lock and coordinates to the first scenario.
- Assert i_reset mid-frame for 1 cycle -> all outputs 0 next cycle; o_locked returns only after the next vsync edge plus one clean frame.
